fetch_queue: RTL

//  Parametrised instruction-fetch front end: owns the fetch PC, issues word reads to a
//  1-cycle-latency instruction memory, buffers {pc, inst} pairs in a DEPTH-entry FIFO and

---
 rtl/fetch_queue.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Owns the fetch PC, issues one word read per
// cycle to a 1-cycle-latency instruction memory, buffers {pc, inst, fault} entries in a
// DEPTH-entry FIFO and presents the head to decode over valid/ready.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect produces a single
// fault entry and halts fetch until the next redirect. Without it, redirect_pc[1:0] is ignored.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   redirect_valid/_pc       flush and restart fetch at redirect_pc (highest priority)
//   imem_req/_addr/_rdata    memory read port, data returns the cycle after the request
//   out_valid/_ready         decode handshake; out_inst/out_pc/out_fault describe the head
//   level                    number of occupied FIFO entries

// Generic FIFO with synchronous flush; caller guarantees no push when full, no pop when empty.
// Latency: a pushed entry is visible at the head the cycle after the push (no bypass).
// Backpressure: none internally; the producer must track free space from count.
module fq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_rdy,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop_rdy)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_vld, pop_rdy})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// Fetch front end: PC sequencer, single outstanding memory read, entry FIFO toward decode.
// Latency: redirect at T -> imem_req at T+1 -> entry pushed end of T+2 -> out_valid at T+3.
// Backpressure: issue stops while occupied + in-flight entries reach DEPTH; decode stalls never drop data.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [XLEN-1:0]            out_pc,
    output logic                       out_fault,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int LW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            fault;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pend_pc;     // address of the entry that will be pushed next cycle
    logic            pend_vld;    // an entry (memory response or fault) lands next cycle
    logic            pend_fault;
    logic            halt;
    logic            issue;
    logic            push;
    logic            pop;
    logic [LW:0]     credit_used;
    entry_t          push_ent;
    entry_t          head_ent;

    // Credit counts the pending entry but ignores a same-cycle pop, so a push can never
    // meet a full FIFO. Outputs are held at zero while reset is asserted.
    assign credit_used = {1'b0, level} + {{LW{1'b0}}, pend_vld};
    assign issue       = rst && !redirect_valid && !halt && (credit_used < (LW+1)'(DEPTH));
    assign imem_req    = issue;
    assign imem_addr   = issue ? (fetch_pc & ~XLEN'(3)) : '0;

    assign push           = pend_vld && !redirect_valid;
    assign push_ent.pc    = pend_pc;
    assign push_ent.inst  = pend_fault ? 32'h0 : imem_rdata;
    assign push_ent.fault = pend_fault;

    assign out_valid = (level != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign out_inst  = out_valid ? head_ent.inst  : 32'h0;
    assign out_pc    = out_valid ? head_ent.pc    : '0;
    assign out_fault = out_valid ? head_ent.fault : 1'b0;

    fq_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat (push_ent),
        .pop_rdy  (pop),
        .head_dat (head_ent),
        .count    (level)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC;
            pend_vld   <= 1'b0;
            pend_pc    <= '0;
            pend_fault <= 1'b0;
            halt       <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            pend_pc  <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                // No memory access: synthesise one fault entry, then stop until redirected.
                pend_vld   <= 1'b1;
                pend_fault <= 1'b1;
                halt       <= 1'b1;
            end else begin
                pend_vld   <= 1'b0;
                pend_fault <= 1'b0;
                halt       <= 1'b0;
            end
        end else begin
            pend_vld   <= issue;
            pend_pc    <= fetch_pc;
            pend_fault <= 1'b0;
            if (issue) fetch_pc <= fetch_pc + XLEN'(4);
        end
    end
`else
    assign pend_fault = 1'b0;
    assign halt       = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            pend_vld <= 1'b0;
            pend_pc  <= '0;
        end else if (redirect_valid) begin
            // Low address bits are meaningless without the trap feature.
            fetch_pc <= redirect_pc & ~XLEN'(3);
            pend_vld <= 1'b0;
        end else begin
            pend_vld <= issue;
            pend_pc  <= fetch_pc;
            if (issue) fetch_pc <= fetch_pc + XLEN'(4);
        end
    end
`endif
endmodule
